// File: rtl/simon_arb_pkg.sv
// Shared types and sizing helpers for the Simon engine request arbiter.
// Optional grant counters are enabled with SIMON_ARB_PERF_EN.
package simon_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    // Width of the per-requester grant counters
    localparam int CNT_W = 16;

    // Requester id width, never narrower than one bit
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/simon_arb_tag_fifo.sv
// In-order FIFO of requester ids for operations the engine has accepted
// but not yet returned; head names the owner of the next result.
module simon_arb_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         push,
    input  logic [W-1:0] push_id,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/simon_req_arbiter.sv
// Round-robin arbiter sharing one Simon engine among NREQ requesters, with
// in-order result routing; SIMON_ARB_PERF_EN adds per-requester grant counters.
module simon_req_arbiter
    import simon_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WW    = 16,
    parameter int NKW   = 4,
    parameter int OUTST = 2
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ-1:0]       req_mode_i,
    input  logic [NREQ*2*WW-1:0]  req_pt_i,
    input  logic [NREQ*NKW*WW-1:0] req_key_i,
    output logic                  eng_valid_o,
    input  logic                  eng_ready_i,
    output logic                  eng_mode_o,
    output logic [2*WW-1:0]       eng_pt_o,
    output logic [NKW*WW-1:0]     eng_key_o,
    input  logic                  eng_valid_i,
    output logic                  eng_ready_o,
    input  logic                  eng_mode_i,
    input  logic [2*WW-1:0]       eng_ct_i,
    output logic [NREQ-1:0]       rsp_valid_o,
    input  logic [NREQ-1:0]       rsp_ready_i,
    output logic                  rsp_mode_o,
    output logic [2*WW-1:0]       rsp_ct_o,
    output logic                  busy_o,
    output logic                  err_o
`ifdef SIMON_ARB_PERF_EN
    ,
    output logic [NREQ*CNT_W-1:0] grant_cnt_o
`endif
);

    localparam int ID_W  = id_width(NREQ);
    localparam int PT_W  = 2 * WW;
    localparam int KEY_W = NKW * WW;

    arb_state_e      state;
    arb_state_e      state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_nxt;
    logic [ID_W-1:0] lock_id;
    logic [ID_W-1:0] lock_nxt;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] sel_id;
    logic [ID_W-1:0] head_id;
    logic            any_req;
    logic            offer;
    logic            hs;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;

    // Scanning downward lets the lowest offset from rr_ptr win
    always_comb begin
        winner  = rr_ptr;
        any_req = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[(int'(rr_ptr) + k) % NREQ]) begin
                winner  = ID_W'((int'(rr_ptr) + k) % NREQ);
                any_req = 1'b1;
            end
        end
    end

    assign sel_id = (state == LOCKED) ? lock_id : winner;

    always_comb begin
        offer = 1'b0;
        if (!arst) begin
            offer = (state == LOCKED) ? 1'b1 : (any_req && !fifo_full);
        end
    end

    assign hs = offer && eng_ready_i;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_id <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_nxt;
            lock_id <= lock_nxt;
        end
    end

    // A stalled offer is frozen in lock_id so the engine inputs stay stable
    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_id;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (offer && !eng_ready_i) begin
                    state_nxt = LOCKED;
                    lock_nxt  = winner;
                end
            end
            LOCKED: begin
                if (eng_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (hs) begin
            rr_nxt = (sel_id == ID_W'(NREQ - 1)) ? '0 : sel_id + ID_W'(1);
        end
    end

    always_comb begin
        eng_valid_o = 1'b0;
        eng_mode_o  = 1'b0;
        eng_pt_o    = '0;
        eng_key_o   = '0;
        req_ready_o = '0;
        if (offer) begin
            eng_valid_o = 1'b1;
            eng_mode_o  = req_mode_i[sel_id];
            eng_pt_o    = req_pt_i[int'(sel_id)*PT_W +: PT_W];
            eng_key_o   = req_key_i[int'(sel_id)*KEY_W +: KEY_W];
        end
        if (hs) begin
            req_ready_o[sel_id] = 1'b1;
        end
    end

    simon_arb_tag_fifo #(
        .DEPTH(OUTST),
        .W    (ID_W)
    ) u_tag_fifo (
        .clk    (clk),
        .arst   (arst),
        .push   (hs),
        .push_id(sel_id),
        .pop    (fifo_pop),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (head_id)
    );

    // Results are routed to the owner recorded at the FIFO head
    always_comb begin
        eng_ready_o = 1'b0;
        rsp_valid_o = '0;
        rsp_mode_o  = 1'b0;
        rsp_ct_o    = '0;
        if (!arst && !fifo_empty) begin
            eng_ready_o = rsp_ready_i[head_id];
            if (eng_valid_i) begin
                rsp_valid_o[head_id] = 1'b1;
                rsp_mode_o           = eng_mode_i;
                rsp_ct_o             = eng_ct_i;
            end
        end
    end

    assign fifo_pop = eng_valid_i && eng_ready_o;
    assign busy_o   = (state == LOCKED) || !fifo_empty;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            err_o <= 1'b0;
        end else if (eng_valid_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

`ifdef SIMON_ARB_PERF_EN
    logic [CNT_W-1:0] grant_cnt [NREQ];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (hs && sel_id == ID_W'(i) && grant_cnt[i] != '1) begin
                    grant_cnt[i] <= grant_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt_o[i*CNT_W +: CNT_W] = grant_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_simon_req_arbiter.sv
// Randomized scoreboard bench for simon_req_arbiter; the bench plays both the
// requesters and an in-order engine whose result is a fixed function of the inputs.
module tb_simon_req_arbiter;

    localparam int NREQ  = 4;
    localparam int WW    = 16;
    localparam int NKW   = 4;
    localparam int OUTST = 2;
    localparam int PT_W  = 2 * WW;
    localparam int KEY_W = NKW * WW;

    logic                   clk = 1'b0;
    logic                   arst;
    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ-1:0]        req_ready_o;
    logic [NREQ-1:0]        req_mode_i;
    logic [NREQ*PT_W-1:0]   req_pt_i;
    logic [NREQ*KEY_W-1:0]  req_key_i;
    logic                   eng_valid_o;
    logic                   eng_ready_i;
    logic                   eng_mode_o;
    logic [PT_W-1:0]        eng_pt_o;
    logic [KEY_W-1:0]       eng_key_o;
    logic                   eng_valid_i;
    logic                   eng_ready_o;
    logic                   eng_mode_i;
    logic [PT_W-1:0]        eng_ct_i;
    logic [NREQ-1:0]        rsp_valid_o;
    logic [NREQ-1:0]        rsp_ready_i;
    logic                   rsp_mode_o;
    logic [PT_W-1:0]        rsp_ct_o;
    logic                   busy_o;
    logic                   err_o;
`ifdef SIMON_ARB_PERF_EN
    logic [NREQ*16-1:0]     grant_cnt_o;
`endif

    always #5 clk = ~clk;

    simon_req_arbiter #(
        .NREQ (NREQ),
        .WW   (WW),
        .NKW  (NKW),
        .OUTST(OUTST)
    ) dut (
`ifdef SIMON_ARB_PERF_EN
        .grant_cnt_o(grant_cnt_o),
`endif
        .clk        (clk),
        .arst       (arst),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_mode_i (req_mode_i),
        .req_pt_i   (req_pt_i),
        .req_key_i  (req_key_i),
        .eng_valid_o(eng_valid_o),
        .eng_ready_i(eng_ready_i),
        .eng_mode_o (eng_mode_o),
        .eng_pt_o   (eng_pt_o),
        .eng_key_o  (eng_key_o),
        .eng_valid_i(eng_valid_i),
        .eng_ready_o(eng_ready_o),
        .eng_mode_i (eng_mode_i),
        .eng_ct_i   (eng_ct_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_mode_o (rsp_mode_o),
        .rsp_ct_o   (rsp_ct_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    typedef struct {
        int              id;
        logic            mode;
        logic [PT_W-1:0] ct;
    } exp_t;

    typedef struct {
        logic            mode;
        logic [PT_W-1:0] ct;
    } eres_t;

    exp_t  exp_q[$];
    eres_t eng_q[$];
    int    tag_q[$];

    int checks = 0;
    int errors = 0;

    bit               rv   [NREQ];
    logic             rmode[NREQ];
    logic [PT_W-1:0]  rpt  [NREQ];
    logic [KEY_W-1:0] rkey [NREQ];
    int               gcnt [NREQ];
    int               m_rr;
    int               m_offer;
    bit               m_err;
    bit               e_pres;

    // Stand-in for the engine's transform; only needs to be distinctive
    function automatic logic [PT_W-1:0] engine_fn(input logic mode, input logic [PT_W-1:0] pt,
                                                  input logic [KEY_W-1:0] key);
        if (mode) return ~(pt ^ key[PT_W-1:0]) ^ key[KEY_W-1:PT_W];
        return pt + key[PT_W-1:0] + key[KEY_W-1:PT_W];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic newRequest(input int i);
        rv[i]    = 1'b1;
        rmode[i] = 1'($urandom_range(1));
        rpt[i]   = $urandom;
        rkey[i]  = {$urandom, $urandom};
    endtask

    task automatic driveInputs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid_i[i]                 = rv[i];
            req_mode_i[i]                  = rmode[i];
            req_pt_i[i*PT_W +: PT_W]       = rpt[i];
            req_key_i[i*KEY_W +: KEY_W]    = rkey[i];
        end
    endtask

    task automatic resetModel();
        m_rr    = 0;
        m_offer = -1;
        m_err   = 1'b0;
        e_pres  = 1'b0;
        tag_q.delete();
        eng_q.delete();
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    endtask

    // Reset asserted with every requester valid: everything must read zero
    task automatic doReset();
        @(negedge clk);
        arst = 1'b1;
        for (int i = 0; i < NREQ; i++) newRequest(i);
        driveInputs();
        eng_valid_i = 1'b1;
        eng_ready_i = 1'b1;
        eng_mode_i  = 1'b1;
        eng_ct_i    = $urandom;
        rsp_ready_i = '1;
        #1;
        checkOutput("rst_eng_valid", eng_valid_o, 0);
        checkOutput("rst_req_ready", req_ready_o, 0);
        checkOutput("rst_eng_mode", eng_mode_o, 0);
        checkOutput("rst_eng_pt", eng_pt_o, 0);
        checkOutput("rst_eng_key", eng_key_o, 0);
        checkOutput("rst_eng_ready", eng_ready_o, 0);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("rst_rsp_mode", rsp_mode_o, 0);
        checkOutput("rst_rsp_ct", rsp_ct_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_err", err_o, 0);
`ifdef SIMON_ARB_PERF_EN
        checkOutput("rst_grant_cnt", grant_cnt_o, 0);
`endif
        @(posedge clk);
        #1;
        arst        = 1'b0;
        eng_valid_i = 1'b0;
        resetModel();
        for (int i = 0; i < NREQ; i++) rv[i] = 1'b1;
    endtask

    // One clock per iteration: drive at negedge, predict and compare at +1
    task automatic applyStimulus(input int cycles, input int p_new, input int p_eready,
                                 input int p_evalid, input int p_rready,
                                 input bit [NREQ-1:0] new_mask);
        for (int c = 0; c < cycles; c++) begin
            int    exp_id;
            int    head;
            bit    full;
            bit    exp_valid;
            bit    hs;
            bit    rhs;
            eres_t er;
            exp_t  ex;
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i] && new_mask[i] && $urandom_range(99) < p_new) newRequest(i);
            end
            if (!e_pres && eng_q.size() > 0 && $urandom_range(99) < p_evalid) e_pres = 1'b1;
            eng_valid_i = e_pres;
            if (e_pres) begin
                eng_mode_i = eng_q[0].mode;
                eng_ct_i   = eng_q[0].ct;
            end else begin
                eng_mode_i = 1'($urandom_range(1));
                eng_ct_i   = $urandom;
            end
            eng_ready_i = ($urandom_range(99) < p_eready);
            for (int i = 0; i < NREQ; i++) rsp_ready_i[i] = ($urandom_range(99) < p_rready);
            driveInputs();
            #1;
            full      = (tag_q.size() >= OUTST);
            exp_valid = 1'b0;
            exp_id    = 0;
            if (m_offer >= 0) begin
                exp_valid = 1'b1;
                exp_id    = m_offer;
            end else if (!full) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (rv[(m_rr + k) % NREQ]) begin
                        exp_valid = 1'b1;
                        exp_id    = (m_rr + k) % NREQ;
                        break;
                    end
                end
            end
            hs = exp_valid && eng_ready_i;
            checkOutput("eng_valid", eng_valid_o, exp_valid);
            checkOutput("req_ready", req_ready_o, hs ? (1 << exp_id) : 0);
            checkOutput("eng_mode", eng_mode_o, exp_valid ? rmode[exp_id] : 0);
            checkOutput("eng_pt", eng_pt_o, exp_valid ? rpt[exp_id] : 0);
            checkOutput("eng_key", eng_key_o, exp_valid ? rkey[exp_id] : 0);
            head = (tag_q.size() > 0) ? tag_q[0] : -1;
            rhs  = e_pres && head >= 0 && rsp_ready_i[head];
            checkOutput("rsp_valid", rsp_valid_o, (e_pres && head >= 0) ? (1 << head) : 0);
            checkOutput("eng_ready_o", eng_ready_o, head >= 0 && rsp_ready_i[head]);
            checkOutput("busy", busy_o, m_offer >= 0 || tag_q.size() > 0);
            checkOutput("err", err_o, m_err);
            if (hs) begin
                rv[exp_id] = 1'b0;
                tag_q.push_back(exp_id);
                m_rr    = (exp_id + 1) % NREQ;
                m_offer = -1;
                gcnt[exp_id]++;
                er.mode = rmode[exp_id];
                er.ct   = engine_fn(rmode[exp_id], rpt[exp_id], rkey[exp_id]);
                eng_q.push_back(er);
                ex.id   = exp_id;
                ex.mode = er.mode;
                ex.ct   = er.ct;
                exp_q.push_back(ex);
            end else if (exp_valid) begin
                m_offer = exp_id;
            end
            if (rhs) begin
                void'(tag_q.pop_front());
                void'(eng_q.pop_front());
                e_pres = 1'b0;
            end
            if (e_pres && head < 0) m_err = 1'b1;
        end
    endtask

    // Scoreboard monitor: every accepted result must match the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!arst && (rsp_valid_o & rsp_ready_i) != '0) begin
                int id;
                id = -1;
                for (int i = NREQ - 1; i >= 0; i--) if (rsp_valid_o[i]) id = i;
                checkOutput("rsp_onehot", $countones(rsp_valid_o), 1);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: got result for %0d, expected none", id);
                end else begin
                    exp_t ex;
                    ex = exp_q.pop_front();
                    checkOutput("rsp_owner", id, ex.id);
                    checkOutput("rsp_mode", rsp_mode_o, ex.mode);
                    checkOutput("rsp_ct", rsp_ct_o, ex.ct);
                end
            end
        end
    end

    initial begin
        arst        = 1'b1;
        eng_valid_i = 1'b0;
        eng_ready_i = 1'b0;
        eng_mode_i  = 1'b0;
        eng_ct_i    = '0;
        rsp_ready_i = '0;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0;
            newRequest(i);
            rv[i] = 1'b0;
        end
        driveInputs();
        resetModel();
        $display("[TB] starting");

        doReset();
        // Continuous demand with an eager engine: grants rotate 0,1,2,3,0
        applyStimulus(10, 100, 100, 100, 100, '1);
        // Results withheld until the tag FIFO fills, then released
        applyStimulus(6, 100, 100, 0, 100, '1);
        applyStimulus(6, 100, 100, 100, 100, '1);
        applyStimulus(20, 0, 100, 100, 100, '1);

        // Stalled offer to requester 2 must hold while requester 0 joins
        for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
        newRequest(2);
        applyStimulus(1, 0, 0, 0, 100, '0);
        newRequest(0);
        applyStimulus(2, 0, 0, 0, 100, '0);
        applyStimulus(6, 0, 100, 100, 100, '0);

        applyStimulus(3000, 30, 60, 60, 70, '1);
        applyStimulus(40, 0, 100, 100, 100, '1);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
`ifdef SIMON_ARB_PERF_EN
        for (int i = 0; i < NREQ; i++) checkOutput("grant_cnt", grant_cnt_o[i*16 +: 16], gcnt[i]);
`endif

        // Engine result with nothing outstanding
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
        driveInputs();
        eng_valid_i = 1'b1;
        eng_ready_i = 1'b0;
        rsp_ready_i = '1;
        #1;
        checkOutput("orphan_eng_ready", eng_ready_o, 0);
        checkOutput("orphan_rsp_valid", rsp_valid_o, 0);
        @(negedge clk);
        eng_valid_i = 1'b0;
        #1;
        checkOutput("err_set", err_o, 1);
        @(negedge clk);
        #1;
        checkOutput("err_sticky", err_o, 1);
        m_err = 1'b1;

        // Reset in the middle of a stalled offer; afterwards requester 0 wins
        newRequest(2);
        applyStimulus(3, 0, 0, 0, 100, '0);
        doReset();
        applyStimulus(8, 100, 100, 100, 100, '1);

`ifdef SIMON_ARB_PERF_EN
        // Requester 1 alone, enough grants to saturate its counter
        doReset();
        for (int i = 0; i < NREQ; i++) rv[i] = (i == 1);
        applyStimulus(65600, 100, 100, 100, 100, 4'b0010);
        checkOutput("grant_cnt_sat", grant_cnt_o[16 +: 16], (gcnt[1] > 65535) ? 65535 : gcnt[1]);
        checkOutput("grant_cnt_other", grant_cnt_o[0 +: 16], 0);
`endif

        applyStimulus(10, 0, 100, 100, 100, '1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
